// File: rtl/aes_round_pipe.sv
// One AES encryption round (SubBytes, ShiftRows, optional MixColumns, AddRoundKey) with valid/ready flow.
// Latency: PIPE_STAGES clocks from an accepted input beat to out_valid (1 or 2).
// Backpressure: stalled stages hold their beat; empty stages still load; in_ready depends only on out_ready and stage valids.

// SubBytes: S-box applied to every byte, built as GF(2^8) inverse followed by the affine map.
module sub_bytes (
    input  logic [127:0] state,
    output logic [127:0] result
);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0 as AES requires), then affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        inv  = gf_mul(x252, x2);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // Byte-wise substitution; byte position is irrelevant here.
    always_comb begin
        result = '0;
        for (int i = 0; i < 16; i++) begin
            result[8*i +: 8] = sbox(state[8*i +: 8]);
        end
    end

endmodule

// ShiftRows: row r of the column-major state rotates left by r bytes.
module shift_rows (
    input  logic [127:0] state,
    output logic [127:0] result
);

    // Byte (row r, column c) sits at index 4c+r counted from the MSB end.
    always_comb begin
        result = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                result[127 - 8*(4*c + r) -: 8] = state[127 - 8*(4*((c + r) % 4) + r) -: 8];
            end
        end
    end

endmodule

// MixColumns: each column multiplied by the fixed circulant {02,03,01,01} over GF(2^8).
module mix_columns (
    input  logic [127:0] state,
    output logic [127:0] result
);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // One column at a time; 3*a is folded as xtime(a)^a.
    always_comb begin
        logic [7:0] a0, a1, a2, a3;
        result = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = state[127 - 32*c      -: 8];
            a1 = state[127 - 32*c - 8  -: 8];
            a2 = state[127 - 32*c - 16 -: 8];
            a3 = state[127 - 32*c - 24 -: 8];
            result[127 - 32*c      -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            result[127 - 32*c - 8  -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            result[127 - 32*c - 16 -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            result[127 - 32*c - 24 -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
    end

endmodule

// AddRoundKey: plain XOR of state and round key.
module key_add (
    input  logic [127:0] state,
    input  logic [127:0] key,
    output logic [127:0] result
);

    assign result = state ^ key;

endmodule

module aes_round_pipe #(
    parameter int FINAL_ROUND  = 1,
    parameter int PIPE_STAGES  = 1,
    parameter int BLOCK_LENGTH = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    logic [127:0] sb_state;
    logic [127:0] sr_state;
    logic [127:0] mix_src;
    logic [127:0] key_src;
    logic [127:0] mixed;
    logic [127:0] round_out;
    logic         front_valid;
    logic         adv_out;

    if (BLOCK_LENGTH != 128) begin : g_bad_width
        $error("aes_round_pipe: BLOCK_LENGTH must be 128");
    end
    if (PIPE_STAGES != 1 && PIPE_STAGES != 2) begin : g_bad_pipe
        $error("aes_round_pipe: PIPE_STAGES must be 1 or 2");
    end

    sub_bytes  u_sub_bytes  (.state(in_data),  .result(sb_state));
    shift_rows u_shift_rows (.state(sb_state), .result(sr_state));

    // The output register advances when empty or when the consumer takes its beat.
    assign adv_out = !out_valid || out_ready;

    if (PIPE_STAGES == 2) begin : g_two_stage
        logic         s0_valid;
        logic [127:0] s0_data;
        logic [127:0] s0_key;
        logic         adv_s0;

        // s0 may fill a bubble even while the output register is stalled.
        assign adv_s0      = !s0_valid || adv_out;
        assign in_ready    = adv_s0;
        assign mix_src     = s0_data;
        assign key_src     = s0_key;
        assign front_valid = s0_valid;
        assign busy        = s0_valid || out_valid;

        // Mid-round register: shifted state plus the key captured with the same beat.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                s0_valid <= 1'b0;
                s0_data  <= '0;
                s0_key   <= '0;
            end else if (adv_s0) begin
                s0_valid <= in_valid;
                s0_data  <= sr_state;
                s0_key   <= in_key;
            end
        end
    end else begin : g_one_stage
        assign in_ready    = adv_out;
        assign mix_src     = sr_state;
        assign key_src     = in_key;
        assign front_valid = in_valid;
        assign busy        = out_valid;
    end

    if (FINAL_ROUND != 0) begin : g_no_mix
        assign mixed = mix_src;
    end else begin : g_mix
        mix_columns u_mix_columns (.state(mix_src), .result(mixed));
    end

    key_add u_key_add (.state(mixed), .key(key_src), .result(round_out));

    // Output register: loads on every advance; only out_valid says whether the data means anything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (adv_out) begin
            out_valid <= front_valid;
            out_data  <= round_out;
        end
    end

endmodule

// File: tb/tb_aes_round_pipe.sv
// Directed bench for aes_round_pipe: FIPS-197 round vectors on a final-round/1-stage and a mid-round/2-stage instance.
// Key variants rely on AddRoundKey linearity: out(k) = out(k0) ^ k0 ^ k.
// Covers reset, latency, streaming, backpressure, bubble collapse and asynchronous reset.
module tb_aes_round_pipe;

    localparam logic [127:0] IN1  = 128'heb40f21e592e38848ba113e71bc342d2;
    localparam logic [127:0] KEY1 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] OUT1 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] IN2  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] KEY2 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] OUT2 = 128'ha49c7ff2689f352b6b5bea43026a5049;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
    logic [127:0] a_in_data, a_in_key, a_out_data;
    logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
    logic [127:0] b_in_data, b_in_key, b_out_data;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0]   b8;
    logic [127:0] k;
    logic [127:0] exp_a;
    logic [127:0] bexp[$];

    always #5 clk = ~clk;

    aes_round_pipe #(.FINAL_ROUND(1), .PIPE_STAGES(1), .BLOCK_LENGTH(128)) u_final (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_key(a_in_key),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .busy(a_busy)
    );

    aes_round_pipe #(.FINAL_ROUND(0), .PIPE_STAGES(2), .BLOCK_LENGTH(128)) u_mid (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_key(b_in_key),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .busy(b_busy)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        tests_run++;
        if (obs !== expv) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drains u_mid with out_ready high, comparing each emerging beat against bexp in order.
    task automatic drain_b(input string tag);
        int got;
        got = 0;
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            #1;
            if (b_out_valid) begin
                if (got < bexp.size()) check(tag, b_out_data, bexp[got]);
                got++;
            end
            tick();
        end
        check({tag, "_count"}, 128'(got), 128'(bexp.size()));
        check({tag, "_idle"}, 128'(b_busy), 128'd0);
        bexp.delete();
    endtask

    initial begin
        a_in_valid = 1'b0; a_in_data = '0; a_in_key = '0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_in_key = '0; b_out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_a_valid", 128'(a_out_valid), 128'd0);
        check("rst_a_data", a_out_data, 128'd0);
        check("rst_a_busy", 128'(a_busy), 128'd0);
        check("rst_b_valid", 128'(b_out_valid), 128'd0);
        check("rst_b_data", b_out_data, 128'd0);
        check("rst_b_busy", 128'(b_busy), 128'd0);
        rst = 1'b1;
        #1;
        check("rel_a_ready", 128'(a_in_ready), 128'd1);
        check("rel_b_ready", 128'(b_in_ready), 128'd1);

        // T1: final round, one register
        a_in_valid = 1'b1; a_in_data = IN1; a_in_key = KEY1; a_out_ready = 1'b1;
        tick();
        a_in_valid = 1'b0; a_in_data = '0; a_in_key = '1;
        check("t1_valid", 128'(a_out_valid), 128'd1);
        check("t1_data", a_out_data, OUT1);
        tick();
        check("t1_empty", 128'(a_out_valid), 128'd0);

        // T2: middle round, two registers
        b_in_valid = 1'b1; b_in_data = IN2; b_in_key = KEY2; b_out_ready = 1'b1;
        tick();
        b_in_valid = 1'b0; b_in_key = 128'h0123456789abcdef0123456789abcdef;
        check("t2_lat1_valid", 128'(b_out_valid), 128'd0);
        check("t2_lat1_busy", 128'(b_busy), 128'd1);
        tick();
        check("t2_valid", 128'(b_out_valid), 128'd1);
        check("t2_data", b_out_data, OUT2);
        tick();
        check("t2_empty", 128'(b_out_valid), 128'd0);

        // T3: 8 back-to-back beats on u_final with per-beat keys
        a_out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            b8 = 8'(i + 1);
            k  = KEY1 ^ {16{b8}};
            exp_a = OUT1 ^ KEY1 ^ k;
            a_in_valid = 1'b1; a_in_data = IN1; a_in_key = k;
            tick();
            check("t3_valid", 128'(a_out_valid), 128'd1);
            check("t3_data", a_out_data, exp_a);
        end
        a_in_valid = 1'b0;
        tick();
        check("t3_end", 128'(a_out_valid), 128'd0);

        // T4: backpressure on u_mid for 5 clocks while feeding
        b_out_ready = 1'b0; b_in_valid = 1'b1; b_in_data = IN2;
        for (int c = 0; c < 5; c++) begin
            b8 = 8'(8'h10 + c);
            k  = KEY2 ^ {16{b8}};
            b_in_key = k;
            #1;
            check("t4_in_ready", 128'(b_in_ready), (c < 2) ? 128'd1 : 128'd0);
            if (c < 2) bexp.push_back(OUT2 ^ KEY2 ^ k);
            tick();
            if (c == 0) begin
                check("t4_first_valid", 128'(b_out_valid), 128'd0);
            end else begin
                check("t4_hold_valid", 128'(b_out_valid), 128'd1);
                check("t4_hold_data", b_out_data, bexp[0]);
            end
        end
        drain_b("t4_drain");

        // T5: beat, idle, beat with the consumer stalled
        b_out_ready = 1'b0;
        k = KEY2 ^ {16{8'h21}};
        b_in_valid = 1'b1; b_in_key = k; bexp.push_back(OUT2 ^ KEY2 ^ k);
        tick();
        b_in_valid = 1'b0;
        tick();
        k = KEY2 ^ {16{8'h22}};
        b_in_valid = 1'b1; b_in_key = k;
        #1;
        check("t5_bubble_ready", 128'(b_in_ready), 128'd1);
        bexp.push_back(OUT2 ^ KEY2 ^ k);
        tick();
        b_in_valid = 1'b0;
        #1;
        check("t5_busy", 128'(b_busy), 128'd1);
        check("t5_full_ready", 128'(b_in_ready), 128'd0);
        check("t5_valid", 128'(b_out_valid), 128'd1);
        check("t5_data", b_out_data, bexp[0]);
        tick();
        check("t5_stable", b_out_data, bexp[0]);
        drain_b("t5_drain");

        // T6: asynchronous reset between clock edges with beats in flight
        a_out_ready = 1'b1; b_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = IN1; a_in_key = KEY1;
        b_in_valid = 1'b1; b_in_data = IN2; b_in_key = KEY2;
        tick();
        tick();
        a_in_valid = 1'b0; b_in_valid = 1'b0;
        check("t6_pre_a_valid", 128'(a_out_valid), 128'd1);
        check("t6_pre_b_busy", 128'(b_busy), 128'd1);
        #2;
        rst = 1'b0;
        #1;
        check("t6_a_valid", 128'(a_out_valid), 128'd0);
        check("t6_a_data", a_out_data, 128'd0);
        check("t6_a_busy", 128'(a_busy), 128'd0);
        check("t6_b_valid", 128'(b_out_valid), 128'd0);
        check("t6_b_data", b_out_data, 128'd0);
        check("t6_b_busy", 128'(b_busy), 128'd0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        a_in_valid = 1'b1; a_in_data = IN1; a_in_key = KEY1;
        b_in_valid = 1'b1; b_in_data = IN2; b_in_key = KEY2; b_out_ready = 1'b1;
        tick();
        a_in_valid = 1'b0; b_in_valid = 1'b0;
        check("t6_post_a_valid", 128'(a_out_valid), 128'd1);
        check("t6_post_a_data", a_out_data, OUT1);
        tick();
        check("t6_post_b_valid", 128'(b_out_valid), 128'd1);
        check("t6_post_b_data", b_out_data, OUT2);
        tick();
        check("t6_post_b_empty", 128'(b_busy), 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
